// File: rtl/tft_reg_pkg.sv
// Shared definitions for the register-bus arbiter: default bus widths,
// the transaction FSM encoding and a grant-index to one-hot helper.
package tft_reg_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } arb_state_e;

    function automatic logic [1:0] ack_vec(input logic id);
        logic [1:0] vec;
        if (id) begin
            vec = 2'b10;
        end else begin
            vec = 2'b01;
        end
        return vec;
    endfunction

endpackage

// File: rtl/reg_bus_arbiter_rr_arb2.sv
// Two-way round-robin picker. The requester not granted last wins a tie;
// an active lock restricts the grant to the last owner.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       lock,
    output logic       grant,
    output logic       valid
);

    // Winner selection, lock first, then round-robin
    always_comb begin
        grant = last;
        valid = 1'b0;
        if (lock) begin
            grant = last;
            valid = req[last];
        end else begin
            case (req)
                2'b01: begin
                    grant = 1'b0;
                    valid = 1'b1;
                end
                2'b10: begin
                    grant = 1'b1;
                    valid = 1'b1;
                end
                2'b11: begin
                    grant = ~last;
                    valid = 1'b1;
                end
                default: begin
                    grant = last;
                    valid = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Arbitrates the SPI slave and the panel sequencer onto one register bus,
// issuing single-cycle write/read strobes and a one-cycle ack per access.
module reg_bus_arbiter
    import tft_reg_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req,
    input  logic [1:0]             we,
    input  logic [1:0]             lock,
    input  logic [1:0][ADDR_W-1:0] addr,
    input  logic [1:0][DATA_W-1:0] wdata,
    output logic [1:0]             ack,
    output logic [DATA_W-1:0]      rdata,
    output logic [ADDR_W-1:0]      reg_addr,
    output logic [DATA_W-1:0]      reg_wdata,
    output logic                   reg_write,
    output logic                   reg_read,
    input  logic [DATA_W-1:0]      reg_rdata,
    output logic                   busy,
    output logic                   gnt_id
);

    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

    arb_state_e        state_r, state_nxt;
    logic [1:0]        cnt_r, cnt_nxt;
    logic [ADDR_W-1:0] addr_r, addr_nxt;
    logic [DATA_W-1:0] wdata_r, wdata_nxt;
    logic [DATA_W-1:0] rdata_r, rdata_nxt;
    logic              we_r, we_nxt;
    logic              write_r, write_nxt;
    logic              read_r, read_nxt;
    logic [1:0]        ack_r, ack_nxt;
    logic              gnt_r, gnt_nxt;
    logic              last_r, last_nxt;
    logic              hold_r, hold_nxt;
    logic              busy_r;
    logic              lock_act_s;
    logic              pick_s;
    logic              pick_valid_s;

    // The hold only counts while the previous owner keeps its lock raised
    assign lock_act_s = hold_r & lock[last_r];

    rr_arb2 u_rr_arb2 (
        .req   (req),
        .last  (last_r),
        .lock  (lock_act_s),
        .grant (pick_s),
        .valid (pick_valid_s)
    );

    // Next-state and next-output decode for the transaction FSM
    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        addr_nxt  = addr_r;
        wdata_nxt = wdata_r;
        rdata_nxt = rdata_r;
        we_nxt    = we_r;
        write_nxt = 1'b0;
        read_nxt  = 1'b0;
        ack_nxt   = 2'b00;
        gnt_nxt   = gnt_r;
        last_nxt  = last_r;
        hold_nxt  = hold_r;
        case (state_r)
            IDLE: begin
                if (hold_r && !lock[last_r]) begin
                    hold_nxt = 1'b0;
                end else begin
                    hold_nxt = hold_r;
                end
                if (pick_valid_s) begin
                    state_nxt = ISSUE;
                    gnt_nxt   = pick_s;
                    addr_nxt  = addr[pick_s];
                    wdata_nxt = wdata[pick_s];
                    we_nxt    = we[pick_s];
                    write_nxt = we[pick_s];
                    read_nxt  = ~we[pick_s];
                end else begin
                    state_nxt = IDLE;
                end
            end
            ISSUE: begin
                if (we_r) begin
                    state_nxt = RESP;
                    ack_nxt   = ack_vec(gnt_r);
                end else begin
                    state_nxt = WAIT_RD;
                    cnt_nxt   = LAT_LOAD;
                end
            end
            WAIT_RD: begin
                if (cnt_r == 2'd0) begin
                    state_nxt = RESP;
                    rdata_nxt = reg_rdata;
                    ack_nxt   = ack_vec(gnt_r);
                end else begin
                    cnt_nxt = cnt_r - 2'd1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
                last_nxt  = gnt_r;
                hold_nxt  = lock[gnt_r];
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; the last pointer resets to 1 so requester 0 leads
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 2'd0;
            addr_r  <= '0;
            wdata_r <= '0;
            rdata_r <= '0;
            we_r    <= 1'b0;
            write_r <= 1'b0;
            read_r  <= 1'b0;
            ack_r   <= 2'b00;
            gnt_r   <= 1'b0;
            last_r  <= 1'b1;
            hold_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
            addr_r  <= addr_nxt;
            wdata_r <= wdata_nxt;
            rdata_r <= rdata_nxt;
            we_r    <= we_nxt;
            write_r <= write_nxt;
            read_r  <= read_nxt;
            ack_r   <= ack_nxt;
            gnt_r   <= gnt_nxt;
            last_r  <= last_nxt;
            hold_r  <= hold_nxt;
            busy_r  <= (state_nxt != IDLE);
        end
    end

    assign ack       = ack_r;
    assign rdata     = rdata_r;
    assign reg_addr  = addr_r;
    assign reg_wdata = wdata_r;
    assign reg_write = write_r;
    assign reg_read  = read_r;
    assign busy      = busy_r;
    assign gnt_id    = gnt_r;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: one instance with RD_LAT=1 for the
// main scenarios and one with RD_LAT=4 for the long read path.
module tb_reg_bus_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req, we, lock;
    logic [1:0][7:0]  addr;
    logic [1:0][31:0] wdata;
    logic [1:0]       ack;
    logic [31:0]      rdata, reg_wdata, reg_rdata;
    logic [7:0]       reg_addr;
    logic             reg_write, reg_read, busy, gnt_id;

    logic [1:0]       req4, we4, lock4;
    logic [1:0][7:0]  addr4;
    logic [1:0][31:0] wdata4;
    logic [1:0]       ack4;
    logic [31:0]      rdata4, reg_wdata4, reg_rdata4;
    logic [7:0]       reg_addr4;
    logic             reg_write4, reg_read4, busy4, gnt_id4;

    int checks = 0;
    int errors = 0;
    int ack_cnt;
    logic exp_g;

    always #5 clk = ~clk;

    reg_bus_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock), .addr(addr),
        .wdata(wdata), .ack(ack), .rdata(rdata), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_write(reg_write), .reg_read(reg_read),
        .reg_rdata(reg_rdata), .busy(busy), .gnt_id(gnt_id)
    );

    reg_bus_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(4)) dut4 (
        .clk(clk), .rst(rst), .req(req4), .we(we4), .lock(lock4), .addr(addr4),
        .wdata(wdata4), .ack(ack4), .rdata(rdata4), .reg_addr(reg_addr4),
        .reg_wdata(reg_wdata4), .reg_write(reg_write4), .reg_read(reg_read4),
        .reg_rdata(reg_rdata4), .busy(busy4), .gnt_id(gnt_id4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; we = 2'b00; lock = 2'b00; addr = '0; wdata = '0;
        reg_rdata = 32'h0;
        req4 = 2'b00; we4 = 2'b00; lock4 = 2'b00; addr4 = '0; wdata4 = '0;
        reg_rdata4 = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ack", 64'(ack), 64'h0);
        chk("rst_strobes", 64'({reg_write, reg_read}), 64'h0);
        chk("rst_busy_gnt", 64'({busy, gnt_id}), 64'h0);
        chk("rst_addr", 64'(reg_addr), 64'h0);
        chk("rst_wdata", 64'(reg_wdata), 64'h0);
        chk("rst_rdata", 64'(rdata), 64'h0);

        // req0 write; drops req and changes addr mid-transaction
        req = 2'b01; we = 2'b01; addr[0] = 8'h10; wdata[0] = 32'hDEADBEEF;
        tick();
        chk("wr_strobes", 64'({reg_write, reg_read}), 64'h2);
        chk("wr_addr", 64'(reg_addr), 64'h10);
        chk("wr_wdata", 64'(reg_wdata), 64'hDEADBEEF);
        chk("wr_busy_gnt", 64'({busy, gnt_id}), 64'h2);
        chk("wr_no_early_ack", 64'(ack), 64'h0);
        req = 2'b00; addr[0] = 8'h77;
        tick();
        chk("wr_ack", 64'(ack), 64'h1);
        chk("wr_strobe_off", 64'({reg_write, reg_read}), 64'h0);
        chk("wr_rdata_kept", 64'(rdata), 64'h0);
        chk("wr_addr_held", 64'(reg_addr), 64'h10);
        tick();
        chk("wr_ack_one", 64'(ack), 64'h0);
        chk("wr_idle", 64'(busy), 64'h0);

        // req1 read with RD_LAT=1
        req = 2'b10; we = 2'b00; addr[1] = 8'h05;
        tick();
        chk("rd_strobes", 64'({reg_write, reg_read}), 64'h1);
        chk("rd_addr", 64'(reg_addr), 64'h05);
        chk("rd_gnt", 64'(gnt_id), 64'h1);
        req = 2'b00; reg_rdata = 32'h00000005;
        tick();
        chk("rd_wait_ack", 64'(ack), 64'h0);
        chk("rd_wait_strobes", 64'({reg_write, reg_read}), 64'h0);
        chk("rd_wait_addr", 64'(reg_addr), 64'h05);
        tick();
        reg_rdata = 32'hFFFF0000;
        chk("rd_ack", 64'(ack), 64'h2);
        chk("rd_data", 64'(rdata), 64'h5);
        tick();
        chk("rd_ack_one", 64'(ack), 64'h0);
        chk("rd_data_hold", 64'(rdata), 64'h5);

        // both requesters, four writes each: grants alternate starting at 0
        req = 2'b11; we = 2'b11; ack_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            wdata[0] = 32'hA0000000 + 32'(k);
            wdata[1] = 32'hB0000000 + 32'(k);
            exp_g = k[0];
            tick();
            chk("rr_gnt", 64'(gnt_id), 64'(exp_g));
            chk("rr_strobes", 64'({reg_write, reg_read, ack}), 64'h8);
            chk("rr_wdata", 64'(reg_wdata), exp_g ? 64'hB0000000 + 64'(k) : 64'hA0000000 + 64'(k));
            tick();
            chk("rr_ack", 64'({reg_write, reg_read, ack}), exp_g ? 64'h2 : 64'h1);
            if (ack != 2'b00) ack_cnt++;
            tick();
        end
        chk("rr_ack_count", 64'(ack_cnt), 64'd8);

        // lock on requester 0 for three transactions while req1 waits
        lock = 2'b01;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("lock_gnt", 64'(gnt_id), 64'h0);
            tick();
            chk("lock_ack", 64'(ack), 64'h1);
            tick();
        end
        lock = 2'b00;
        tick();
        chk("unlock_gnt", 64'(gnt_id), 64'h1);
        req = 2'b00;
        tick();
        chk("unlock_ack", 64'(ack), 64'h2);
        tick();

        // reset during WAIT_RD aborts the read
        req = 2'b01; we = 2'b00; addr[0] = 8'h33;
        tick();
        chk("abort_read_issued", 64'(reg_read), 64'h1);
        req = 2'b00; reg_rdata = 32'h12345678;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ack", 64'(ack), 64'h0);
        chk("abort_busy", 64'({busy, reg_write, reg_read}), 64'h0);
        chk("abort_addr_rdata", 64'({reg_addr, rdata}), 64'h0);
        tick();
        chk("abort_no_late_ack", 64'(ack), 64'h0);
        req = 2'b10; we = 2'b10; addr[1] = 8'h44; wdata[1] = 32'h0000CAFE;
        tick();
        chk("post_rst_issue", 64'({reg_write, gnt_id, reg_addr}), 64'h344);
        req = 2'b00;
        tick();
        chk("post_rst_ack", 64'(ack), 64'h2);
        tick();

        // RD_LAT=4: capture the bank value presented four cycles after reg_read
        req4 = 2'b10; we4 = 2'b00; addr4[1] = 8'h5A;
        tick();
        chk("lat4_read", 64'({reg_read4, reg_addr4}), 64'h15A);
        req4 = 2'b00; reg_rdata4 = 32'h11111111;
        for (int c = 2; c < 6; c++) begin
            tick();
            reg_rdata4 = 32'h11111111 * 32'(c);
            chk("lat4_wait", 64'(ack4), 64'h0);
        end
        tick();
        reg_rdata4 = 32'h0;
        chk("lat4_ack", 64'(ack4), 64'h2);
        chk("lat4_data", 64'(rdata4), 64'h55555555);
        tick();
        chk("lat4_ack_one", 64'(ack4), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bus_arbiter.md
REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, register address width.
REQ-002 Parameter DATA_W, default 32, register data width.
REQ-003 Parameter RD_LAT, default 1, legal 1..4, cycles from reg_read pulse to valid reg_rdata.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req  in  2  per-requester request (bit 0 = SPI slave side, bit 1 = internal panel sequencer).
REQ-007 we  in  2  per-requester write enable (1 = write, 0 = read).
REQ-008 lock  in  2  per-requester bus-hold for atomic multi-access sequences.
REQ-009 addr  in  2 x ADDR_W  per-requester register address.
REQ-010 wdata  in  2 x DATA_W  per-requester write data.
REQ-011 ack  out  2  one-cycle completion pulse to the granted requester.
REQ-012 rdata  out  DATA_W  read data, valid in the ack cycle.
REQ-013 reg_addr, reg_wdata  out  ADDR_W, DATA_W  shared register bus address and data.
REQ-014 reg_write, reg_read  out  1 each  shared bus one-cycle strobes.
REQ-015 reg_rdata  in  DATA_W  shared register bank read data.
REQ-016 busy  out  1  high in any state except IDLE; gnt_id  out  1  index of the current or last grant.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT_RD, RESP.
REQ-018 IDLE: no req -> stay; else pick a winner, latch its we/addr/wdata, set gnt_id, go ISSUE.
REQ-019 Arbitration is round-robin: the requester not granted last has priority; a single requester always wins.
REQ-020 Lock override: if lock[g] was high in the RESP cycle of grant g, IDLE grants only g while lock[g] stays high; lock drop releases it to round-robin in the same cycle.
REQ-021 ISSUE: drive latched addr/wdata on reg_addr/reg_wdata, pulse reg_write (write) or reg_read (read) for exactly one cycle; write -> RESP, read -> WAIT_RD.
REQ-022 WAIT_RD: hold reg_addr; after RD_LAT cycles capture reg_rdata into rdata, go RESP.
REQ-023 RESP: pulse ack[gnt_id] for one cycle, update round-robin pointer, go IDLE.
REQ-024 Latency from the IDLE sampling cycle to ack: write 2 cycles, read 2+RD_LAT cycles.
REQ-025 Throughput: one IDLE cycle minimum between transactions; a requester drops req the cycle after ack and is not serviced twice.
REQ-026 req, we, addr, wdata are sampled only in IDLE; changes mid-transaction are ignored.
REQ-027 A req dropped before ack does not abort: the transaction completes and ack still pulses.
REQ-028 Simultaneous req from both: exactly one grant; the other is served next IDLE unless lock holds.
REQ-029 rdata holds its last captured value between reads; writes do not modify it.
REQ-030 reg_write, reg_read, ack never high in the same cycle; at most one ack bit high per cycle.

Reset
REQ-031 rst forces IDLE; ack, reg_write, reg_read, busy, gnt_id, reg_addr, reg_wdata, rdata all 0.
REQ-032 Round-robin pointer resets to favour requester 0; lock hold cleared.
REQ-033 rst asserted mid-transaction aborts it: no pending strobe or ack is issued afterwards.

Structure
REQ-034 Package tft_reg_pkg holds ADDR_W/DATA_W defaults and the FSM state enum.
REQ-035 Sub-module rr_arb2: 2-way round-robin picker (req, last grant, lock in -> grant index out), combinational.
REQ-036 RD_LAT counter is 2 bits wide.

Verification
REQ-037 Req0 write addr 0x10 data 0xDEADBEEF -> reg_write one cycle with those values, ack[0] 2 cycles after sampling, rdata unchanged.
REQ-038 Req1 read addr 0x05, bank returns 0x00000005, RD_LAT=1 -> reg_read one cycle, ack[1] at cycle 3, rdata=0x00000005.
REQ-039 Both req continuously, 4 writes each -> grants alternate 0,1,0,1..., 8 acks, no overlapping strobes.
REQ-040 Req0 with lock high for 3 transactions while req1 pending -> three consecutive grants to 0; req1 granted first IDLE after lock drops.
REQ-041 rst pulsed in WAIT_RD -> no ack, outputs 0 next cycle, next request completes normally.
REQ-042 RD_LAT=4 read -> ack at cycle 6; rdata equals reg_rdata sampled 4 cycles after reg_read.
